// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared types and constants for the UART transmit path.
//   - UART_DATA_BITS / UART_IDX_W : frame payload width and its bit-index width
//   - uart_byte_t                 : one payload byte
//   - tx_state_e                  : transmitter FSM encoding
//   - tx_line_level()             : serial line level for a given FSM position
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned UART_IDX_W     = $clog2(UART_DATA_BITS);

    typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Line level the transmitter drives while sitting in a given state/bit.
    function automatic logic tx_line_level(
        input tx_state_e              st,
        input uart_byte_t             shift,
        input logic [UART_IDX_W-1:0]  idx
    );
        logic level;
        case (st)
            ST_START: level = 1'b0;
            ST_DATA:  level = shift[idx];
            default:  level = 1'b1;
        endcase
        return level;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// -----------------------------------------------------------------------------
// uart_tx_if
//   Byte-producer handshake into the UART transmitter.
//   i_Tx_DV    producer valid; a byte is taken on a clock edge where
//              i_Tx_DV && o_Tx_Ready
//   i_Tx_Byte  byte to send, sampled only on accept
//   o_Tx_Ready transmitter can accept a byte (input FIFO not full)
//   master : producer side     slave : transmitter side
// -----------------------------------------------------------------------------
interface uart_tx_if;
    import uart_pkg::*;

    logic       i_Tx_DV;
    uart_byte_t i_Tx_Byte;
    logic       o_Tx_Ready;

    modport master (
        output i_Tx_DV,
        output i_Tx_Byte,
        input  o_Tx_Ready
    );

    modport slave (
        input  i_Tx_DV,
        input  i_Tx_Byte,
        output o_Tx_Ready
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   FIFO_DEPTH x 8 synchronous FIFO in front of the UART serialiser.
//   Ports:
//     i_Clock, i_Rst_n  clock, async active-low reset
//     i_push            write i_push_data (ignored while full)
//     i_push_data       byte to store
//     i_pop             drop the head entry (ignored while empty)
//     o_head_c          current head entry (combinational read of storage)
//     o_ready           registered "not full"
//     o_empty           registered "empty"
//     o_count           registered occupancy, 0..FIFO_DEPTH
//   Push and pop in the same cycle leave the occupancy unchanged.
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Rst_n,
    input  logic                          i_push,
    input  uart_byte_t                    i_push_data,
    input  logic                          i_pop,
    output uart_byte_t                    o_head_c,
    output logic                          o_ready,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    uart_byte_t         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_ready;
    logic               r_empty;

    logic               w_push;
    logic               w_pop;
    logic [CNT_W-1:0]   w_count_next;

    // Guard against misuse so occupancy can never over/underflow.
    assign w_push = i_push && r_ready;
    assign w_pop  = i_pop  && !r_empty;

    // Occupancy update.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Pointers wrap naturally at PTR_W bits (depth is a power of two).
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b1;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_next;
            r_ready <= (w_count_next != CNT_W'(FIFO_DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    // Storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge i_Clock) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head_c = r_mem[r_rd_ptr];
    assign o_ready  = r_ready;
    assign o_empty  = r_empty;
    assign o_count  = r_count;

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   UART 8N1 transmitter with a small input FIFO. Serialises queued bytes as
//   start(0), 8 data bits LSB first, stop(1); the line idles high.
//   Ports:
//     i_Clock, i_Rst_n  clock, async active-low reset
//     tx_if (slave)     producer handshake: i_Tx_DV / i_Tx_Byte / o_Tx_Ready
//     o_Tx_Serial       registered serial line
//     o_Tx_Active       high from the first START cycle to the last STOP cycle
//     o_Tx_Done         one-cycle pulse in the last clock of each stop bit
//     o_Fifo_Count      bytes currently queued, 0..FIFO_DEPTH
//   Back-to-back frames leave no idle gap: the next byte is popped in the last
//   STOP cycle and START follows directly.
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 174,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Rst_n,
    uart_tx_if.slave                      tx_if,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Done,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]      BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [UART_IDX_W-1:0] IDX_LAST = UART_IDX_W'(UART_DATA_BITS - 1);

    // FSM and datapath state
    tx_state_e              r_state;
    tx_state_e              w_state_next;
    logic [CNT_W-1:0]       r_clk_cnt;
    logic [CNT_W-1:0]       w_clk_cnt_next;
    logic [UART_IDX_W-1:0]  r_bit_idx;
    logic [UART_IDX_W-1:0]  w_bit_idx_next;
    uart_byte_t             r_shift;
    uart_byte_t             w_shift_next;

    // Output registers and their next values
    logic                   r_tx_serial;
    logic                   r_tx_active;
    logic                   r_tx_done;
    logic                   w_serial_next;
    logic                   w_active_next;
    logic                   w_done_next;

    // FIFO interface
    logic                   w_push;
    logic                   w_pop;
    logic                   w_bit_end;
    logic                   w_fifo_ready;
    logic                   w_fifo_empty;
    uart_byte_t             w_fifo_head;

    assign w_push            = tx_if.i_Tx_DV && w_fifo_ready;
    assign tx_if.o_Tx_Ready  = w_fifo_ready;

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_Clock     (i_Clock),
        .i_Rst_n     (i_Rst_n),
        .i_push      (w_push),
        .i_push_data (tx_if.i_Tx_Byte),
        .i_pop       (w_pop),
        .o_head_c    (w_fifo_head),
        .o_ready     (w_fifo_ready),
        .o_empty     (w_fifo_empty),
        .o_count     (o_Fifo_Count)
    );

    assign w_bit_end = (r_clk_cnt == BIT_LAST);

    // State, counters and output registers.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state     <= ST_IDLE;
            r_clk_cnt   <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_tx_serial <= 1'b1;
            r_tx_active <= 1'b0;
            r_tx_done   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_clk_cnt   <= w_clk_cnt_next;
            r_bit_idx   <= w_bit_idx_next;
            r_shift     <= w_shift_next;
            r_tx_serial <= w_serial_next;
            r_tx_active <= w_active_next;
            r_tx_done   <= w_done_next;
        end
    end

    // Next-state logic; outputs are derived from the next position so the
    // registered line changes on the same edge the FSM enters a bit.
    always_comb begin
        w_state_next   = r_state;
        w_clk_cnt_next = r_clk_cnt;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_pop          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_clk_cnt_next = '0;
                w_bit_idx_next = '0;
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_fifo_head;
                    w_state_next = ST_START;
                end
            end

            ST_START: begin
                if (w_bit_end) begin
                    w_clk_cnt_next = '0;
                    w_bit_idx_next = '0;
                    w_state_next   = ST_DATA;
                end else begin
                    w_clk_cnt_next = r_clk_cnt + CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (w_bit_end) begin
                    w_clk_cnt_next = '0;
                    if (r_bit_idx == IDX_LAST) begin
                        w_bit_idx_next = '0;
                        w_state_next   = ST_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + UART_IDX_W'(1);
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + CNT_W'(1);
                end
            end

            ST_STOP: begin
                if (w_bit_end) begin
                    w_clk_cnt_next = '0;
                    w_bit_idx_next = '0;
                    // Chain straight into the next frame when data is waiting.
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_fifo_head;
                        w_state_next = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state_next   = ST_IDLE;
                w_clk_cnt_next = '0;
                w_bit_idx_next = '0;
            end
        endcase

        w_serial_next = tx_line_level(w_state_next, w_shift_next, w_bit_idx_next);
        w_active_next = (w_state_next != ST_IDLE);
        w_done_next   = (w_state_next == ST_STOP) && (w_clk_cnt_next == BIT_LAST);
    end

    assign o_Tx_Serial = r_tx_serial;
    assign o_Tx_Active = r_tx_active;
    assign o_Tx_Done   = r_tx_done;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//   Directed bench for uart_tx: a fast instance (4 clocks/bit) for framing,
//   FIFO and reset behaviour, and a slow instance (174 clocks/bit) decoded at
//   mid-bit. Inputs change and outputs are sampled 1 time unit after posedge.
// -----------------------------------------------------------------------------
module tb_uart_tx;
    import uart_pkg::*;

    localparam int unsigned CPB_FAST = 4;
    localparam int unsigned CPB_SLOW = 174;
    localparam int unsigned DEPTH    = 4;

    logic        clk;
    logic        rst_n;
    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_miss = 0;
    int          s_done_cnt = 0;

    logic        f_serial, f_active, f_done;
    logic [2:0]  f_count;
    logic        s_serial, s_active, s_done;
    logic [2:0]  s_count;

    logic [7:0]  t3_bytes [5] = '{8'h00, 8'hFF, 8'h55, 8'h3C, 8'h81};
    int          t3_cnt   [5] = '{1, 1, 2, 3, 4};
    int          t3_rdy   [5] = '{1, 1, 1, 1, 0};

    uart_tx_if if_f ();
    uart_tx_if if_s ();

    uart_tx #(.CLKS_PER_BIT(CPB_FAST), .FIFO_DEPTH(DEPTH)) u_dut_fast (
        .i_Clock      (clk),
        .i_Rst_n      (rst_n),
        .tx_if        (if_f),
        .o_Tx_Serial  (f_serial),
        .o_Tx_Active  (f_active),
        .o_Tx_Done    (f_done),
        .o_Fifo_Count (f_count)
    );

    uart_tx #(.CLKS_PER_BIT(CPB_SLOW), .FIFO_DEPTH(DEPTH)) u_dut_slow (
        .i_Clock      (clk),
        .i_Rst_n      (rst_n),
        .tx_if        (if_s),
        .o_Tx_Serial  (s_serial),
        .o_Tx_Active  (s_active),
        .o_Tx_Done    (s_done),
        .o_Fifo_Count (s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (s_done) s_done_cnt <= s_done_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at frame clock 1; checks every clock of a fast frame and
    // returns at clock 41 (the next frame's clock 1 when back-to-back).
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int k = 0; k < 40; k++) begin
            chk($sformatf("%s serial clk%0d", tag, k + 1), 32'(f_serial), 32'(fr[k / CPB_FAST]));
            chk($sformatf("%s active clk%0d", tag, k + 1), 32'(f_active), 32'd1);
            chk($sformatf("%s done clk%0d", tag, k + 1), 32'(f_done), 32'(k == 39));
            step(1);
        end
    endtask

    task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input string tag);
        logic [7:0] v [3];
        int         expc [3];
        v = '{a, b, c};
        expc = '{1, 1, 2};
        for (int i = 0; i < 3; i++) begin
            if_f.i_Tx_Byte = v[i];
            if_f.i_Tx_DV   = 1'b1;
            step(1);
            chk($sformatf("%s count after push%0d", tag, i), 32'(f_count), 32'(expc[i]));
        end
        if_f.i_Tx_DV = 1'b0;
    endtask

    initial begin
        int          lows;
        int          dones;
        int          budget;
        int unsigned cyc_start;
        logic [9:0]  got;

        rst_n          = 1'b1;
        if_f.i_Tx_DV   = 1'b0;
        if_f.i_Tx_Byte = 8'h00;
        if_s.i_Tx_DV   = 1'b0;
        if_s.i_Tx_Byte = 8'h00;
        #1 rst_n = 1'b0;
        #1;

        // 1. reset values and a quiet idle line
        chk("rst serial", 32'(f_serial), 32'd1);
        chk("rst active", 32'(f_active), 32'd0);
        chk("rst done",   32'(f_done),   32'd0);
        chk("rst ready",  32'(if_f.o_Tx_Ready), 32'd1);
        chk("rst count",  32'(f_count),  32'd0);
        chk("rst slow serial", 32'(s_serial), 32'd1);
        step(3);
        rst_n = 1'b1;
        lows = 0;
        dones = 0;
        repeat (50) begin
            step(1);
            if (!f_serial) lows++;
            if (f_done) dones++;
        end
        chk("idle low clocks", 32'(lows), 32'd0);
        chk("idle done pulses", 32'(dones), 32'd0);
        chk("idle ready", 32'(if_f.o_Tx_Ready), 32'd1);
        chk("idle count", 32'(f_count), 32'd0);

        // 2. single byte, one-clock latency, exact framing
        if_f.i_Tx_Byte = 8'hA5;
        if_f.i_Tx_DV   = 1'b1;
        step(1);
        if_f.i_Tx_DV   = 1'b0;
        chk("t2 count at accept", 32'(f_count), 32'd1);
        chk("t2 line at accept",  32'(f_serial), 32'd1);
        step(1);
        chk("t2 count at start",  32'(f_count), 32'd0);
        check_frame(8'hA5, "t2");
        chk("t2 serial after", 32'(f_serial), 32'd1);
        chk("t2 active after", 32'(f_active), 32'd0);

        // 3. five bytes with valid held, FIFO fills, gapless frames
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    if_f.i_Tx_Byte = t3_bytes[i];
                    if_f.i_Tx_DV   = 1'b1;
                    step(1);
                    chk($sformatf("t3 count push%0d", i), 32'(f_count), 32'(t3_cnt[i]));
                    chk($sformatf("t3 ready push%0d", i), 32'(if_f.o_Tx_Ready), 32'(t3_rdy[i]));
                end
                if_f.i_Tx_DV = 1'b0;
                step(36);
                chk("t3 ready still full", 32'(if_f.o_Tx_Ready), 32'd0);
                chk("t3 count still full", 32'(f_count), 32'd4);
                step(1);
                chk("t3 ready after pop", 32'(if_f.o_Tx_Ready), 32'd1);
                chk("t3 count after pop", 32'(f_count), 32'd3);
            end
            begin
                step(2);
                for (int i = 0; i < 5; i++)
                    check_frame(t3_bytes[i], $sformatf("t3 byte%0d", i));
                chk("t3 serial after", 32'(f_serial), 32'd1);
                chk("t3 active after", 32'(f_active), 32'd0);
                chk("t3 count after",  32'(f_count),  32'd0);
            end
        join

        // 4. push and pop in the same cycle at the end of STOP
        push3(8'h11, 8'h22, 8'h33, "t4");
        step(38);
        chk("t4 done at stop end", 32'(f_done), 32'd1);
        chk("t4 count before", 32'(f_count), 32'd2);
        if_f.i_Tx_Byte = 8'h44;
        if_f.i_Tx_DV   = 1'b1;
        step(1);
        if_f.i_Tx_DV   = 1'b0;
        chk("t4 count push+pop", 32'(f_count), 32'd2);
        check_frame(8'h22, "t4 b");
        check_frame(8'h33, "t4 c");
        check_frame(8'h44, "t4 d");
        chk("t4 count drained", 32'(f_count), 32'd0);
        chk("t4 active drained", 32'(f_active), 32'd0);

        // 5. reset in DATA bit 3 of 8'hC3 with two bytes queued
        push3(8'hC3, 8'hE7, 8'h18, "t5");
        step(16);
        chk("t5 line in bit3", 32'(f_serial), 32'd0);
        chk("t5 count queued", 32'(f_count), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("t5 line in reset",   32'(f_serial), 32'd1);
        chk("t5 count in reset",  32'(f_count),  32'd0);
        chk("t5 active in reset", 32'(f_active), 32'd0);
        chk("t5 ready in reset",  32'(if_f.o_Tx_Ready), 32'd1);
        step(2);
        rst_n = 1'b1;
        step(3);
        chk("t5 line after release",  32'(f_serial), 32'd1);
        chk("t5 count after release", 32'(f_count),  32'd0);
        if_f.i_Tx_Byte = 8'h5A;
        if_f.i_Tx_DV   = 1'b1;
        step(1);
        if_f.i_Tx_DV   = 1'b0;
        step(1);
        check_frame(8'h5A, "t5");
        lows = 0;
        repeat (20) begin
            if (!f_serial) lows++;
            step(1);
        end
        chk("t5 no stale frames", 32'(lows), 32'd0);
        chk("t5 count final", 32'(f_count), 32'd0);

        // 6. 174 clocks/bit, mid-bit decode of 8'h7E
        s_done_cnt = 0;
        if_s.i_Tx_Byte = 8'h7E;
        if_s.i_Tx_DV   = 1'b1;
        step(1);
        if_s.i_Tx_DV   = 1'b0;
        step(1);
        chk("t6 start latency", 32'(s_serial), 32'd0);
        cyc_start = cyc;
        step(86);
        for (int b = 0; b < 10; b++) begin
            got[b] = s_serial;
            if (b < 9) step(174);
        end
        chk("t6 start bit", 32'(got[0]), 32'd0);
        chk("t6 data byte", 32'(got[8:1]), 32'h7E);
        chk("t6 stop bit",  32'(got[9]), 32'd1);
        budget = 400;
        while (s_active && budget > 0) begin
            step(1);
            budget--;
        end
        chk("t6 active timeout", 32'(budget == 0), 32'd0);
        chk("t6 frame clocks", 32'(cyc - cyc_start), 32'd1740);
        chk("t6 done pulses", 32'(s_done_cnt), 32'd1);
        chk("t6 line idle", 32'(s_serial), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
